// File: rtl/bcd_calendar_counter_if.sv
// Purpose : bundles the tick, load and BCD time/date signals of the calendar counter.
// Latency : none; wires only.
// Backpressure: none; the tick is a plain one-cycle strobe with no ready.
// Ports   : master drives Enable/load/ld_*, slave (the counter) drives the
//           BCD fields, 12-hour pm flag and the per-field carry pulses.
interface bcd_calendar_counter_if;
   logic       Enable;
   logic       load;
   logic [7:0] ld_sec;
   logic [7:0] ld_min;
   logic [7:0] ld_hour;
   logic [7:0] ld_day;
   logic [7:0] ld_month;
   logic [7:0] ld_year;

   logic [7:0] sec;
   logic [7:0] min;
   logic [7:0] hour;
   logic       pm;
   logic [7:0] day;
   logic [7:0] month;
   logic [7:0] year;
   logic       sec_co;
   logic       min_co;
   logic       hour_co;
   logic       day_co;
   logic       month_co;

   modport master (
      output Enable, load, ld_sec, ld_min, ld_hour, ld_day, ld_month, ld_year,
      input  sec, min, hour, pm, day, month, year,
             sec_co, min_co, hour_co, day_co, month_co
   );

   modport slave (
      input  Enable, load, ld_sec, ld_min, ld_hour, ld_day, ld_month, ld_year,
      output sec, min, hour, pm, day, month, year,
             sec_co, min_co, hour_co, day_co, month_co
   );
endinterface

// File: rtl/bcd_calendar_counter.sv
// Purpose : BCD real-time calendar (sec/min/hour/day/month/yy) with leap years and 12h display.
// Latency : fields and carry pulses update on the same edge that samples Enable or load.
// Backpressure: none; every Enable tick is consumed, load beats Enable, reset beats both.
// Ports   : clock, reset (sync, active-high); bus.slave carries Enable, load and ld_*
//           inputs, BCD outputs sec/min/hour/pm/day/month/year and the *_co wrap pulses.
module bcd_calendar_counter #(
   parameter logic [7:0] RESET_YEAR  = 8'h00,
   parameter logic [7:0] RESET_MONTH = 8'h06,
   parameter logic [7:0] RESET_DAY   = 8'h01,
   parameter bit         LEAP_EN     = 1'b1,
   parameter bit         MODE_12H    = 1'b0
) (
   input  logic                  clock,
   input  logic                  reset,
   bcd_calendar_counter_if.slave bus
);

   logic [7:0] sec_q, min_q, hour_q, day_q, month_q, year_q;
   logic       sec_co_q, min_co_q, hour_co_q, day_co_q, month_co_q;

   function automatic logic [7:0] bcd_inc(input logic [7:0] v);
      if (v[3:0] == 4'd9)
         return {v[7:4] + 4'd1, 4'd0};
      else
         return {v[7:4], v[3:0] + 4'd1};
   endfunction

   // Divisible by 4 read straight off the BCD digits: an even tens digit
   // needs ones in {0,4,8}, an odd tens digit needs ones in {2,6}.
   function automatic logic is_leap(input logic [7:0] y);
      logic even_ok, odd_ok;
      even_ok = !y[4] && (y[3:0] == 4'd0 || y[3:0] == 4'd4 || y[3:0] == 4'd8);
      odd_ok  =  y[4] && (y[3:0] == 4'd2 || y[3:0] == 4'd6);
      return LEAP_EN && (even_ok || odd_ok);
   endfunction

   function automatic logic [7:0] days_in_month(input logic [7:0] m, input logic [7:0] y);
      case (m)
         8'h02:                      return is_leap(y) ? 8'h29 : 8'h28;
         8'h04, 8'h06, 8'h09, 8'h11: return 8'h30;
         default:                    return 8'h31;
      endcase
   endfunction

   // Load sanitising: month forced into 01..12, day into 01..month length.
   // Packed BCD compares numerically as long as the digits are 0-9.
   logic       ld_month_ok;
   logic [7:0] ld_month_fix, ld_dim, ld_day_fix;

   always_comb begin
      ld_month_ok  = (bus.ld_month >= 8'h01 && bus.ld_month <= 8'h09) ||
                     (bus.ld_month >= 8'h10 && bus.ld_month <= 8'h12);
      ld_month_fix = ld_month_ok ? bus.ld_month : 8'h01;
      ld_dim       = days_in_month(ld_month_fix, bus.ld_year);
      if (bus.ld_day == 8'h00)
         ld_day_fix = 8'h01;
      else if (bus.ld_day > ld_dim)
         ld_day_fix = ld_dim;
      else
         ld_day_fix = bus.ld_day;
   end

   // Ripple wrap conditions for one tick; each stage only wraps if all
   // lower stages wrap in the same tick.
   logic [7:0] cur_dim;
   logic       sec_wrap, min_wrap, hour_wrap, day_wrap, month_wrap;

   always_comb begin
      cur_dim    = days_in_month(month_q, year_q);
      sec_wrap   = (sec_q == 8'h59);
      min_wrap   = sec_wrap  && (min_q  == 8'h59);
      hour_wrap  = min_wrap  && (hour_q == 8'h23);
      // >= keeps the counter from running past the month end on odd states
      day_wrap   = hour_wrap && (day_q  >= cur_dim);
      month_wrap = day_wrap  && (month_q == 8'h12);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         sec_q      <= 8'h00;
         min_q      <= 8'h00;
         hour_q     <= 8'h00;
         day_q      <= RESET_DAY;
         month_q    <= RESET_MONTH;
         year_q     <= RESET_YEAR;
         sec_co_q   <= 1'b0;
         min_co_q   <= 1'b0;
         hour_co_q  <= 1'b0;
         day_co_q   <= 1'b0;
         month_co_q <= 1'b0;
      end else if (bus.load) begin
         sec_q      <= bus.ld_sec;
         min_q      <= bus.ld_min;
         hour_q     <= bus.ld_hour;
         day_q      <= ld_day_fix;
         month_q    <= ld_month_fix;
         year_q     <= bus.ld_year;
         sec_co_q   <= 1'b0;
         min_co_q   <= 1'b0;
         hour_co_q  <= 1'b0;
         day_co_q   <= 1'b0;
         month_co_q <= 1'b0;
      end else if (bus.Enable) begin
         sec_q <= sec_wrap ? 8'h00 : bcd_inc(sec_q);
         if (sec_wrap)
            min_q <= min_wrap ? 8'h00 : bcd_inc(min_q);
         if (min_wrap)
            hour_q <= hour_wrap ? 8'h00 : bcd_inc(hour_q);
         if (hour_wrap)
            day_q <= day_wrap ? 8'h01 : bcd_inc(day_q);
         if (day_wrap)
            month_q <= month_wrap ? 8'h01 : bcd_inc(month_q);
         if (month_wrap)
            year_q <= (year_q == 8'h99) ? 8'h00 : bcd_inc(year_q);
         sec_co_q   <= sec_wrap;
         min_co_q   <= min_wrap;
         hour_co_q  <= hour_wrap;
         day_co_q   <= day_wrap;
         month_co_q <= month_wrap;
      end else begin
         sec_co_q   <= 1'b0;
         min_co_q   <= 1'b0;
         hour_co_q  <= 1'b0;
         day_co_q   <= 1'b0;
         month_co_q <= 1'b0;
      end
   end

   // 12-hour view of the internal 24-hour count. Hours 13-19 map to 01-07
   // by dropping 2 from the ones digit; 20-23 map to 08-11.
   logic [7:0] hour_disp;
   logic       pm_disp;

   always_comb begin
      hour_disp = hour_q;
      pm_disp   = 1'b0;
      if (MODE_12H) begin
         if (hour_q == 8'h00) begin
            hour_disp = 8'h12;
         end else if (hour_q >= 8'h12) begin
            pm_disp = 1'b1;
            if (hour_q == 8'h12)
               hour_disp = 8'h12;
            else if (hour_q[7:4] == 4'h1)
               hour_disp = {4'h0, hour_q[3:0] - 4'd2};
            else if (hour_q[3:0] < 4'd2)
               hour_disp = {4'h0, hour_q[3:0] + 4'd8};
            else
               hour_disp = {4'h1, hour_q[3:0] - 4'd2};
         end
      end
   end

   assign bus.sec      = sec_q;
   assign bus.min      = min_q;
   assign bus.hour     = hour_disp;
   assign bus.pm       = pm_disp;
   assign bus.day      = day_q;
   assign bus.month    = month_q;
   assign bus.year     = year_q;
   assign bus.sec_co   = sec_co_q;
   assign bus.min_co   = min_co_q;
   assign bus.hour_co  = hour_co_q;
   assign bus.day_co   = day_co_q;
   assign bus.month_co = month_co_q;

endmodule
